// File: rtl/zeroriscy_data_arbiter_pkg.sv
// Shared types for the zero-riscy data-port arbiter: FSM states and master IDs.
package zeroriscy_defines;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam logic ARB_M_CORE = 1'b0;
  localparam logic ARB_M_DBG  = 1'b1;

  // Round-robin tie break: favour whichever master did not win last.
  function automatic logic arb_rr_pick(input logic last_winner);
    return ~last_winner;
  endfunction

endpackage

// File: rtl/zeroriscy_arb_id_fifo.sv
// Response-routing FIFO: remembers which master issued each accepted request.
// Head is read combinationally so rvalid can be steered in the same cycle.
module zeroriscy_arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             id_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign head    = id_mem[rd_ptr_reg];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) id_mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/zeroriscy_data_arbiter.sv
// Two-master arbiter for the zero-riscy data port (LSU = m0, debug/DMA = m1).
// Define ZERORISCY_ARB_FIXED_PRIO_EN to make m0 win every tie instead of round-robin.
module zeroriscy_data_arbiter
  import zeroriscy_defines::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_req_i,
  input  logic                    m1_req_i,
  input  logic                    m0_we_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m0_gnt_o,
  output logic                    m1_gnt_o,
  output logic                    m0_rvalid_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m_rdata_o,
  output logic                    m_err_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_err_i,
  output logic                    arb_orphan_o
);

  arb_state_e state_reg, state_next;
  logic       owner_reg, owner_next;
  logic       tie_winner;
  logic       sel, sel_req, handshake;
  logic       fifo_full, fifo_empty, fifo_head, fifo_pop;
  logic       orphan_reg;

`ifdef ZERORISCY_ARB_FIXED_PRIO_EN
  assign tie_winner = ARB_M_CORE;
`else
  logic last_reg;

  // Reset value 1 makes the first tie go to the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_reg <= ARB_M_DBG;
    else if (handshake) last_reg <= sel;
  end

  assign tie_winner = arb_rr_pick(last_reg);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ARB_IDLE;
      owner_reg  <= ARB_M_CORE;
      orphan_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      if (mem_rvalid_i && fifo_empty) orphan_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_next = ARB_LOCKED;
          owner_next = sel;
        end
      end
      ARB_LOCKED: begin
        // A dropped request while locked is a master bug; release rather than hang.
        if (!sel_req || handshake) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    sel     = owner_reg;
    sel_req = 1'b0;
    if (state_reg == ARB_IDLE) begin
      if (m0_req_i && m1_req_i) sel = tie_winner;
      else if (m1_req_i)        sel = ARB_M_DBG;
      else                      sel = ARB_M_CORE;
      sel_req = m0_req_i | m1_req_i;
    end else begin
      sel_req = (owner_reg == ARB_M_DBG) ? m1_req_i : m0_req_i;
    end

    // Full gates forwarding regardless of a same-cycle pop, so rvalid never reaches req.
    mem_req_o   = sel_req & ~fifo_full;
    mem_we_o    = (sel == ARB_M_DBG) ? m1_we_i    : m0_we_i;
    mem_be_o    = (sel == ARB_M_DBG) ? m1_be_i    : m0_be_i;
    mem_addr_o  = (sel == ARB_M_DBG) ? m1_addr_i  : m0_addr_i;
    mem_wdata_o = (sel == ARB_M_DBG) ? m1_wdata_i : m0_wdata_i;

    handshake = mem_req_o & mem_gnt_i;
    m0_gnt_o  = handshake & (sel == ARB_M_CORE);
    m1_gnt_o  = handshake & (sel == ARB_M_DBG);

    fifo_pop    = mem_rvalid_i & ~fifo_empty;
    m0_rvalid_o = fifo_pop & (fifo_head == ARB_M_CORE);
    m1_rvalid_o = fifo_pop & (fifo_head == ARB_M_DBG);
  end

  assign m_rdata_o    = mem_rdata_i;
  assign m_err_o      = mem_err_i;
  assign arb_orphan_o = orphan_reg;

  zeroriscy_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (handshake),
    .pop   (fifo_pop),
    .din   (sel),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

`ifndef SYNTHESIS
  owner_holds_req: assert property (@(posedge clk) disable iff (!rst_n)
    (state_reg == ARB_LOCKED) |-> sel_req);
`endif

endmodule

// File: tb/tb_zeroriscy_data_arbiter.sv
// Directed bench for zeroriscy_data_arbiter: reset, single master, tie, lock,
// full, ordering, orphan and mid-transaction reset.
module tb_zeroriscy_data_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m_rdata;
  logic        m_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_rdata;
  logic        orphan;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  zeroriscy_data_arbiter #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_req_i     (m0_req),
    .m1_req_i     (m1_req),
    .m0_we_i      (m0_we),
    .m1_we_i      (m1_we),
    .m0_be_i      (m0_be),
    .m1_be_i      (m1_be),
    .m0_addr_i    (m0_addr),
    .m1_addr_i    (m1_addr),
    .m0_wdata_i   (m0_wdata),
    .m1_wdata_i   (m1_wdata),
    .m0_gnt_o     (m0_gnt),
    .m1_gnt_o     (m1_gnt),
    .m0_rvalid_o  (m0_rvalid),
    .m1_rvalid_o  (m1_rvalid),
    .m_rdata_o    (m_rdata),
    .m_err_o      (m_err),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .mem_err_i    (mem_err),
    .arb_orphan_o (orphan)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected winner of tie cycle i when the first tie follows an m0 grant.
  function automatic logic tie_exp(input int i);
`ifdef ZERORISCY_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return (i % 2 == 0) ? 1'b1 : 1'b0;
`endif
  endfunction

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_be = 4'hF; m1_be = 4'h3;
    m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'hA0A0A0A0; m1_wdata = 32'hB1B1B1B1;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'h0; mem_err = 0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    chk("rst_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    chk("rst_orphan", 32'(orphan), 32'h0);
    #11 rst_n = 1'b1;
    tick();

    // Single master read with same-cycle grant, response two cycles later.
    m0_req = 1; m0_addr = 32'h100; mem_gnt = 1; #1;
    chk("single_req", 32'(mem_req), 32'h1);
    chk("single_addr", mem_addr, 32'h100);
    chk("single_be", 32'(mem_be), 32'hF);
    chk("single_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    tick();
    m0_req = 0; mem_gnt = 0; #1;
    chk("single_gnt_once", 32'(m0_gnt), 32'h0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #1;
    chk("single_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h1);
    chk("single_rdata", m_rdata, 32'hDEADBEEF);
    tick();
    mem_rvalid = 0; #1;
    chk("single_rvalid_off", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);

    // Tie with grant every cycle; responses follow one cycle behind.
    m0_addr = 32'h1000; m1_addr = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      m0_req = 1; m1_req = 1; mem_gnt = 1; mem_rvalid = (i > 0); #1;
      chk($sformatf("tie_gnt%0d", i), {30'h0, m1_gnt, m0_gnt},
          tie_exp(i) ? 32'h2 : 32'h1);
      chk($sformatf("tie_addr%0d", i), mem_addr, tie_exp(i) ? 32'h2000 : 32'h1000);
      if (i > 0)
        chk($sformatf("tie_rvalid%0d", i), {30'h0, m1_rvalid, m0_rvalid},
            tie_exp(i - 1) ? 32'h2 : 32'h1);
      tick();
    end
    m0_req = 0; m1_req = 0; mem_gnt = 0; mem_rvalid = 1; #1;
    chk("tie_drain", {30'h0, m1_rvalid, m0_rvalid}, tie_exp(3) ? 32'h2 : 32'h1);
    tick();
    mem_rvalid = 0;

    // Lock: m1 waits three cycles for grant while m0 joins in.
    m1_req = 1; #1;
    chk("lock_addr0", mem_addr, 32'h2000);
    chk("lock_gnt0", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    tick();
    m0_req = 1; #1;
    chk("lock_addr1", mem_addr, 32'h2000);
    chk("lock_we1", 32'(mem_we), 32'h0);
    chk("lock_req1", 32'(mem_req), 32'h1);
    tick();
    chk("lock_addr2", mem_addr, 32'h2000);
    tick();
    mem_gnt = 1; #1;
    chk("lock_gnt3", {30'h0, m1_gnt, m0_gnt}, 32'h2);
    chk("lock_wdata3", mem_wdata, 32'hB1B1B1B1);
    tick();
    m1_req = 0; #1;
    chk("lock_next_m0", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    chk("lock_next_addr", mem_addr, 32'h1000);
    tick();

    // Full: two outstanding (m1, m0), no forwarding until a pop has retired.
    m0_addr = 32'h3000; mem_gnt = 1; #1;
    chk("full_req", 32'(mem_req), 32'h0);
    chk("full_gnt", 32'(m0_gnt), 32'h0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h11; #1;
    chk("full_req_pop", 32'(mem_req), 32'h0);
    chk("full_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h2);
    tick();
    mem_rvalid = 0; #1;
    chk("full_req_after", 32'(mem_req), 32'h1);
    chk("full_gnt_after", 32'(m0_gnt), 32'h1);
    tick();
    m0_req = 0; mem_gnt = 0; mem_rvalid = 1; #1;
    chk("full_drain0", {30'h0, m1_rvalid, m0_rvalid}, 32'h1);
    tick();
    chk("full_drain1", {30'h0, m1_rvalid, m0_rvalid}, 32'h1);
    tick();
    mem_rvalid = 0;

    // Ordering: m0 then m1 granted, responses return in issue order.
    m0_req = 1; mem_gnt = 1; #1;
    chk("ord_gnt0", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    tick();
    m0_req = 0; m1_req = 1; #1;
    chk("ord_gnt1", {30'h0, m1_gnt, m0_gnt}, 32'h2);
    tick();
    m1_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1; #1;
    chk("ord_rv0", {30'h0, m1_rvalid, m0_rvalid}, 32'h1);
    chk("ord_rdata0", m_rdata, 32'h1);
    tick();
    mem_rdata = 32'h2; #1;
    chk("ord_rv1", {30'h0, m1_rvalid, m0_rvalid}, 32'h2);
    chk("ord_rdata1", m_rdata, 32'h2);
    tick();
    mem_rvalid = 0; #1;

    // Orphan response with nothing outstanding.
    chk("orphan_pre", 32'(orphan), 32'h0);
    mem_rvalid = 1; mem_err = 1; #1;
    chk("orphan_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    chk("orphan_err", 32'(m_err), 32'h1);
    tick();
    mem_rvalid = 0; mem_err = 0; #1;
    chk("orphan_set", 32'(orphan), 32'h1);
    tick();
    chk("orphan_sticky", 32'(orphan), 32'h1);

    // Asynchronous reset with two transactions outstanding.
    m0_req = 1; mem_gnt = 1; #1;
    chk("rst2_gnt0", 32'(m0_gnt), 32'h1);
    tick();
    chk("rst2_gnt1", 32'(m0_gnt), 32'h1);
    tick();
    m0_req = 0; mem_gnt = 0; #1;
    rst_n = 1'b0; #1;
    chk("rst2_orphan", 32'(orphan), 32'h0);
    chk("rst2_req", 32'(mem_req), 32'h0);
    chk("rst2_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    chk("rst2_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    mem_rvalid = 1; mem_rdata = 32'h55; #1;
    chk("rst2_discard", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    tick();
    mem_rvalid = 0; #1;
    chk("rst2_empty", 32'(orphan), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
